// File: rtl/control_unit_pkg.sv
// control_pkg: shared types and encodings for the accumulator CPU controller.
//   opcode_t : 5-bit instruction opcodes (0x00-0x0F defined, 0x10-0x1F illegal)
//   state_t  : controller FSM states
//   SEL_A_*, SEL_B_*, ALU_* : datapath select and ALU operation encodings
//   is_defined() : true for opcodes the controller implements
package control_pkg;

    typedef enum logic [4:0] {
        OP_HLT  = 5'h00,
        OP_STO  = 5'h01,
        OP_LD   = 5'h02,
        OP_LDI  = 5'h03,
        OP_ADD  = 5'h04,
        OP_ADDI = 5'h05,
        OP_SUB  = 5'h06,
        OP_SUBI = 5'h07,
        OP_BEQ  = 5'h08,
        OP_BNE  = 5'h09,
        OP_BGT  = 5'h0A,
        OP_BGE  = 5'h0B,
        OP_BLT  = 5'h0C,
        OP_BLE  = 5'h0D,
        OP_JMP  = 5'h0E,
        OP_NOP  = 5'h0F
    } opcode_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    localparam logic SEL_B_MEM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    function automatic logic is_defined(input logic [4:0] code);
        return code < 5'h10;
    endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// branch_cond: combinational branch decision.
//   opcode : current instruction opcode
//   flag_z : datapath zero flag
//   flag_n : datapath negative flag
//   taken  : 1 when the opcode is a branch/jump whose condition holds
module branch_cond
    import control_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = flag_z;
            OP_BNE:  taken = !flag_z;
            OP_BGT:  taken = !flag_n && !flag_z;
            OP_BGE:  taken = !flag_n;
            OP_BLT:  taken = flag_n;
            OP_BLE:  taken = flag_n || flag_z;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle controller for the accumulator CPU.
//   clock_in, reset_n_in         : clock (rising edge), async active-low reset
//   instruction_in               : instruction memory data, valid one cycle after pc_out
//   flag_Z_in, flag_N_in         : datapath status flags for conditional branches
//   pc_out, operand_out          : instruction address, IR operand field
//   sel_A_out, sel_B_out, alu_op_out : datapath selects and ALU operation
//   acc_wr_out, status_wr_out, mem_wr_out : write enables
//   acc_reset_out, status_reset_out       : datapath clears (INIT only)
//   halted_out, illegal_out      : core stopped, sticky undefined-opcode flag
module control_unit
    import control_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic [DATA_WIDTH-1:0]    instruction_in,
    input  logic                     flag_Z_in,
    input  logic                     flag_N_in,
    output logic [OPERAND_WIDTH-1:0] pc_out,
    output logic [OPERAND_WIDTH-1:0] operand_out,
    output logic [1:0]               sel_A_out,
    output logic                     sel_B_out,
    output logic                     alu_op_out,
    output logic                     acc_wr_out,
    output logic                     status_wr_out,
    output logic                     mem_wr_out,
    output logic                     acc_reset_out,
    output logic                     status_reset_out,
    output logic                     halted_out,
    output logic                     illegal_out
);

    state_t                   state;
    state_t                   state_next;
    logic [DATA_WIDTH-1:0]    ir;
    logic [OPERAND_WIDTH-1:0] pc;
    logic                     illegal;
    opcode_t                  op;
    logic                     taken;

    assign op          = opcode_t'(ir[DATA_WIDTH-1:OPERAND_WIDTH]);
    assign pc_out      = pc;
    assign operand_out = ir[OPERAND_WIDTH-1:0];
    assign illegal_out = illegal;

    branch_cond u_branch_cond (
        .opcode (op),
        .flag_z (flag_Z_in),
        .flag_n (flag_N_in),
        .taken  (taken)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state   <= S_INIT;
            pc      <= '0;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                ir <= instruction_in;
                pc <= pc + 1'b1;
            end
            // A taken branch in EXEC replaces the increment made in DECODE.
            if (state == S_EXEC && taken) begin
                pc <= ir[OPERAND_WIDTH-1:0];
            end
            if (state == S_EXEC && !is_defined(op)) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state;
        sel_A_out        = SEL_A_MEM;
        sel_B_out        = SEL_B_MEM;
        alu_op_out       = ALU_ADD;
        acc_wr_out       = 1'b0;
        status_wr_out    = 1'b0;
        mem_wr_out       = 1'b0;
        acc_reset_out    = 1'b0;
        status_reset_out = 1'b0;
        halted_out       = 1'b0;
        case (state)
            S_INIT: begin
                // State sits in INIT throughout reset; the clears are only
                // driven for the single cycle after reset is released.
                acc_reset_out    = reset_n_in;
                status_reset_out = reset_n_in;
                state_next       = S_FETCH;
            end
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                case (op)
                    OP_HLT: state_next = S_HALT;
                    OP_STO: mem_wr_out = 1'b1;
                    OP_LD, OP_ADD, OP_SUB: state_next = S_WB;
                    OP_LDI: begin
                        acc_wr_out = 1'b1;
                        sel_A_out  = SEL_A_IMM;
                    end
                    OP_ADDI, OP_SUBI: begin
                        sel_B_out     = SEL_B_IMM;
                        sel_A_out     = SEL_A_ALU;
                        acc_wr_out    = 1'b1;
                        status_wr_out = 1'b1;
                        alu_op_out    = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
                    end
                    default: begin
                        if (!is_defined(op)) state_next = S_HALT;
                    end
                endcase
            end
            S_WB: begin
                state_next = S_FETCH;
                acc_wr_out = 1'b1;
                if (op != OP_LD) begin
                    sel_A_out     = SEL_A_ALU;
                    sel_B_out     = SEL_B_MEM;
                    status_wr_out = 1'b1;
                    alu_op_out    = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                end
            end
            S_HALT:  halted_out = 1'b1;
            default: state_next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: bench for control_unit. Surrounds the controller with an
// instruction memory, a read-synchronous data memory and an accumulator
// datapath, and checks it against an instruction-level model of the ISA.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        fz, fn;
    logic [10:0] pc_out, operand;
    logic [1:0]  sel_a;
    logic        sel_b, alu_op, acc_wr, status_wr, mem_wr;
    logic        acc_reset, status_reset, halted, illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_unit #(.DATA_WIDTH(16), .OPERAND_WIDTH(11)) dut (
        .clock_in         (clk),
        .reset_n_in       (rst_n),
        .instruction_in   (instr),
        .flag_Z_in        (fz),
        .flag_N_in        (fn),
        .pc_out           (pc_out),
        .operand_out      (operand),
        .sel_A_out        (sel_a),
        .sel_B_out        (sel_b),
        .alu_op_out       (alu_op),
        .acc_wr_out       (acc_wr),
        .status_wr_out    (status_wr),
        .mem_wr_out       (mem_wr),
        .acc_reset_out    (acc_reset),
        .status_reset_out (status_reset),
        .halted_out       (halted),
        .illegal_out      (illegal)
    );

    // ---------------- environment: memories and datapath ----------------
    logic [15:0] imem  [0:2047];
    logic [15:0] dinit [0:2047];
    logic [15:0] dmem  [0:2047];
    logic [15:0] rdata, acc, alu_b, alu_res;

    always_comb begin
        alu_b   = sel_b ? {5'b0, operand} : rdata;
        alu_res = alu_op ? acc - alu_b : acc + alu_b;
    end

    always @(posedge clk) begin
        instr <= imem[pc_out];
        rdata <= dmem[operand];
        if (acc_reset) acc <= '0;
        else if (acc_wr) begin
            case (sel_a)
                2'b00:   acc <= rdata;
                2'b01:   acc <= {5'b0, operand};
                default: acc <= alu_res;
            endcase
        end
        if (status_reset) begin
            fz <= 1'b0;
            fn <= 1'b0;
        end else if (status_wr) begin
            fz <= (alu_res == 16'h0000);
            fn <= alu_res[15];
        end
        if (!rst_n) dmem <= dinit;
        else if (mem_wr) dmem[operand] <= acc;
    end

    // ---------------- reference model state ----------------
    logic [15:0] m_mem [0:2047];
    logic [10:0] m_pc;
    logic [15:0] m_acc;
    logic        m_z, m_n;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_obs();
        return {acc_wr, status_wr, mem_wr, sel_a, sel_b, alu_op, acc_reset, status_reset, halted};
    endfunction

    // Controls expected on the last cycle of an instruction:
    // {acc_wr,status_wr,mem_wr,sel_a,sel_b,alu_op,acc_reset,status_reset,halted}
    function automatic logic [9:0] wr_pattern(input logic [4:0] op);
        case (op)
            5'h01:   return 10'b001_00_0_0_000;
            5'h02:   return 10'b100_00_0_0_000;
            5'h03:   return 10'b100_01_0_0_000;
            5'h04:   return 10'b110_10_0_0_000;
            5'h05:   return 10'b110_10_1_0_000;
            5'h06:   return 10'b110_10_0_1_000;
            5'h07:   return 10'b110_10_1_1_000;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", 32'(ctrl_obs()), 32'h0);
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_ctrl", 32'(ctrl_obs()), 32'(10'b000_00_0_0_110));
    endtask

    // Executes the loaded program one instruction at a time. Starts in INIT.
    task automatic run(input int max_steps);
        logic [15:0] w, src;
        logic [4:0]  op;
        logic [10:0] opd;
        int          len;
        bit          stop, taken, bad;
        m_pc  = '0;
        m_acc = '0;
        m_z   = 1'b0;
        m_n   = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 2048; i++) m_mem[i] = dinit[i];
        for (int s = 0; s < max_steps && !stop; s++) begin
            w   = imem[m_pc];
            op  = w[15:11];
            opd = w[10:0];
            len = (op == 5'h02 || op == 5'h04 || op == 5'h06) ? 4 : 3;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    check("pc_fetch", 32'(pc_out), 32'(m_pc));
                    check("acc", 32'(acc), 32'(m_acc));
                    check("flags", 32'({fz, fn}), 32'({m_z, m_n}));
                end
                if (k >= 2) check("operand", 32'(operand), 32'(opd));
                check($sformatf("ctrl op%0h c%0d", op, k), 32'(ctrl_obs()),
                      32'((k == len - 1) ? wr_pattern(op) : 10'b0));
            end
            taken = 1'b0;
            bad   = 1'b0;
            case (op)
                5'h00: stop = 1'b1;
                5'h01: m_mem[opd] = m_acc;
                5'h02: m_acc = m_mem[opd];
                5'h03: m_acc = {5'b0, opd};
                5'h04, 5'h05, 5'h06, 5'h07: begin
                    src   = (op[0]) ? {5'b0, opd} : m_mem[opd];
                    m_acc = (op >= 5'h06) ? m_acc - src : m_acc + src;
                    m_z   = (m_acc == 16'h0000);
                    m_n   = m_acc[15];
                end
                5'h08: taken = m_z;
                5'h09: taken = !m_z;
                5'h0A: taken = !m_n && !m_z;
                5'h0B: taken = !m_n;
                5'h0C: taken = m_n;
                5'h0D: taken = m_n || m_z;
                5'h0E: taken = 1'b1;
                5'h0F: ;
                default: begin
                    stop = 1'b1;
                    bad  = 1'b1;
                end
            endcase
            m_pc = taken ? opd : m_pc + 11'd1;
            if (stop) begin
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    check("halt_ctrl", 32'(ctrl_obs()), 32'(10'b000_00_0_0_001));
                    check("halt_illegal", 32'(illegal), 32'(bad));
                    check("halt_pc", 32'(pc_out), 32'(m_pc));
                end
            end
        end
    endtask

    task automatic branch_case(input logic [10:0] a, input logic [10:0] b, input logic [4:0] bop);
        clear_imem();
        imem[0]      = enc(5'h03, a);
        imem[1]      = enc(5'h07, b);
        imem[2]      = enc(bop, 11'h100);
        imem[3]      = enc(5'h0F, 11'h0);
        imem[11'h100] = enc(5'h0F, 11'h0);
        do_reset();
        run(5);
    endtask

    function automatic logic [15:0] rand_instr();
        int unsigned v;
        logic [4:0]  op;
        logic [10:0] opd;
        v = $urandom_range(0, 99);
        if (v < 3) op = 5'h00;
        else if (v < 6) op = 5'(5'h10 + $urandom_range(0, 15));
        else op = 5'($urandom_range(1, 15));
        if (op >= 5'h08 && op <= 5'h0E) opd = 11'($urandom_range(0, 31));
        else opd = 11'($urandom);
        return enc(op, opd);
    endfunction

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2048; i++) dinit[i] = 16'($urandom);

        // LDI 5; HLT
        clear_imem();
        imem[0] = enc(5'h03, 11'd5);
        imem[1] = enc(5'h00, 11'd0);
        do_reset();
        run(5);
        check("ldi_hlt_pc", 32'(pc_out), 32'd2);
        check("ldi_hlt_acc", 32'(acc), 32'd5);

        // LD 0x010; ADD 0x011; STO 0x012; HLT
        clear_imem();
        imem[0] = enc(5'h02, 11'h010);
        imem[1] = enc(5'h04, 11'h011);
        imem[2] = enc(5'h01, 11'h012);
        dinit[11'h010] = 16'd7;
        dinit[11'h011] = 16'd9;
        do_reset();
        run(6);
        check("sto_mem", 32'(dmem[11'h012]), 32'd16);

        // LDI 3; SUBI 3 / SUBI 2; BEQ 0x020
        clear_imem();
        imem[0] = enc(5'h03, 11'd3);
        imem[1] = enc(5'h07, 11'd3);
        imem[2] = enc(5'h08, 11'h020);
        do_reset();
        run(6);
        check("beq_taken_pc", 32'(pc_out), 32'h021);
        imem[1] = enc(5'h07, 11'd2);
        do_reset();
        run(6);
        check("beq_not_taken_pc", 32'(pc_out), 32'h004);

        // Conditional branch sweep over (Z,N) = 00, 01, 10
        for (int unsigned b = 5'h0A; b <= 5'h0D; b++) begin
            branch_case(11'd5, 11'd2, 5'(b));
            branch_case(11'd2, 11'd5, 5'(b));
            branch_case(11'd3, 11'd3, 5'(b));
        end

        // PC wrap
        clear_imem();
        imem[0]      = enc(5'h0E, 11'h7FF);
        imem[11'h7FF] = enc(5'h0F, 11'h0);
        do_reset();
        run(4);

        // Illegal opcode
        clear_imem();
        imem[0] = enc(5'h03, 11'd1);
        imem[1] = enc(5'h1F, 11'h2AA);
        do_reset();
        run(5);
        check("illegal_sticky", 32'(illegal), 32'd1);

        // Reset during WB of LD aborts the write, then restart from 0
        clear_imem();
        imem[0] = enc(5'h02, 11'h005);
        dinit[5] = 16'h1234;
        do_reset();
        repeat (4) @(negedge clk);
        check("midwb_accwr", 32'(acc_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midwb_abort", 32'(ctrl_obs()), 32'h0);
        check("midwb_pc", 32'(pc_out), 32'h0);
        do_reset();
        run(4);

        // Random programs
        for (int r = 0; r < 12; r++) begin
            clear_imem();
            for (int a = 0; a < 32; a++) imem[a] = rand_instr();
            for (int i = 0; i < 2048; i++) dinit[i] = 16'($urandom);
            do_reset();
            run(60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
